// File: rtl/qr_pkg.sv
// Shared fixed-point definitions for the QR decomposition / recomposition blocks.
// Latency: n/a (types, constants, helpers only).
// Backpressure: n/a.
package qr_pkg;

    localparam int ELEM_W = 16;
    localparam int FRAC   = 8;
    localparam int N      = 4;
    localparam int ROW_W  = N * ELEM_W;
    localparam int ACC_W  = 2 * ELEM_W + 2;

    localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'((1 << (ELEM_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN    = ~SAT_MAX;
    localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(1 << (FRAC - 1));

    typedef enum logic {
        ST_IDLE,
        ST_MAC
    } qr_state_t;

    // Column 0 lives in the MSBs of a packed row.
    function automatic logic signed [ELEM_W-1:0] get_elem(input logic [ROW_W-1:0] row,
                                                          input logic [1:0]       col);
        return row[ROW_W - 1 - ELEM_W * int'(col) -: ELEM_W];
    endfunction

endpackage

// File: rtl/qr_recompose_if.sv
// Request/result bundle between a matrix producer and qr_recompose.
// Latency: n/a (wiring only).
// Backpressure: none; start is a one-cycle request, busy/done report progress.
interface qr_recompose_if;
    import qr_pkg::*;

    logic             start;
    logic [ROW_W-1:0] q0, q1, q2, q3;
    logic [ROW_W-1:0] r0, r1, r2, r3;
    logic [ROW_W-1:0] a0, a1, a2, a3;
    logic             busy;
    logic             done;

    modport master (
        output start, q0, q1, q2, q3, r0, r1, r2, r3,
        input  a0, a1, a2, a3, busy, done
    );

    modport slave (
        input  start, q0, q1, q2, q3, r0, r1, r2, r3,
        output a0, a1, a2, a3, busy, done
    );

endinterface

// File: rtl/qr_mac_sat.sv
// Signed multiply, load-or-accumulate, then round-half-up and saturate to one element.
// Latency: combinational.
// Backpressure: none.
module qr_mac_sat
    import qr_pkg::*;
(
    input  logic signed [ELEM_W-1:0] q_elem,
    input  logic signed [ELEM_W-1:0] r_elem,
    input  logic signed [ACC_W-1:0]  acc_in,
    input  logic                     load,
    output logic signed [ACC_W-1:0]  sum,
    output logic signed [ELEM_W-1:0] elem
);

    logic signed [2*ELEM_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    rounded;

    assign prod     = q_elem * r_elem;
    assign prod_ext = {{(ACC_W - 2*ELEM_W){prod[2*ELEM_W-1]}}, prod};
    assign sum      = load ? prod_ext : acc_in + prod_ext;
    // Four full products plus the bias still fit ACC_W, so the add cannot wrap.
    assign rounded  = (sum + ROUND_BIAS) >>> FRAC;

    always_comb begin
        elem = rounded[ELEM_W-1:0];
        if (rounded > SAT_MAX) begin
            elem = SAT_MAX[ELEM_W-1:0];
        end else if (rounded < SAT_MIN) begin
            elem = SAT_MIN[ELEM_W-1:0];
        end
    end

endmodule

// File: rtl/qr_recompose.sv
// Rebuilds A = Q*R (4x4 fixed point) with one shared MAC walking i, j, k (k fastest).
// Latency: 65 cycles from the start cycle to the done pulse; busy for 64 cycles.
// Backpressure: none; start while busy is dropped, start on the done cycle is accepted.
module qr_recompose
    import qr_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    qr_recompose_if.slave  bus
);

    qr_state_t               state;
    logic [ROW_W-1:0]        qreg [N];
    logic [ROW_W-1:0]        rreg [N];
    logic [ROW_W-1:0]        areg [N];
    logic [1:0]              i, j, k;
    logic signed [ACC_W-1:0] acc;
    logic                    busy_r;
    logic                    done_r;

    logic signed [ACC_W-1:0]  mac_sum;
    logic signed [ELEM_W-1:0] mac_elem;

    qr_mac_sat u_mac (
        .q_elem (get_elem(qreg[i], k)),
        .r_elem (get_elem(rreg[k], j)),
        .acc_in (acc),
        .load   (k == 2'd0),
        .sum    (mac_sum),
        .elem   (mac_elem)
    );

    assign bus.a0   = areg[0];
    assign bus.a1   = areg[1];
    assign bus.a2   = areg[2];
    assign bus.a3   = areg[3];
    assign bus.busy = busy_r;
    assign bus.done = done_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            acc    <= '0;
            for (int n = 0; n < N; n++) begin
                qreg[n] <= '0;
                rreg[n] <= '0;
                areg[n] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        qreg[0] <= bus.q0;
                        qreg[1] <= bus.q1;
                        qreg[2] <= bus.q2;
                        qreg[3] <= bus.q3;
                        rreg[0] <= bus.r0;
                        rreg[1] <= bus.r1;
                        rreg[2] <= bus.r2;
                        rreg[3] <= bus.r3;
                        i       <= '0;
                        j       <= '0;
                        k       <= '0;
                        busy_r  <= 1'b1;
                        state   <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc <= mac_sum;
                    k   <= k + 2'd1;
                    if (k == 2'd3) begin
                        areg[i][ROW_W - 1 - ELEM_W * int'(j) -: ELEM_W] <= mac_elem;
                        j <= j + 2'd1;
                        if (j == 2'd3) begin
                            i <= i + 2'd1;
                            if (i == 2'd3) begin
                                busy_r <= 1'b0;
                                done_r <= 1'b1;
                                state  <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/qr_recompose.md
Name: qr_recompose

Overview:
- Inverse direction of the QR decomposition path: takes a 4x4 orthogonal Q and upper-triangular R and rebuilds A = Q*R.
- Used in the precoder datapath to close the loop on decomposition accuracy (residual check) and to regenerate A after R-domain processing.
- Sequential, area-lean: one shared signed multiply-accumulate unit walks all 64 products, with a start/busy/done handshake.

Parameters:
- ELEM_W, 16, signed element width; each 64-bit row packs 4 elements.
- FRAC, 8, fractional bits of the fixed-point format (Q8.8 at defaults).
- ACC_W, 2*ELEM_W+2, accumulator width; holds 4 full products without overflow.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- Q0,Q1,Q2,Q3  input  64  rows of Q; element c of a row occupies bits [63-16c : 48-16c], so column 0 is the MSBs.
- R0,R1,R2,R3  input  64  rows of R, same packing.
- A0,A1,A2,A3  output  64  rows of result A, same packing; registered.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse when A0..A3 hold a complete new result.

Behaviour:
- Reset (reset=0, any time, asynchronous): A0..A3=0, busy=0, done=0, FSM=IDLE, all indices and the accumulator cleared.
- Reset mid-operation aborts the computation; no done pulse follows.
- IDLE:
  - start=1 at edge T0 latches all eight input rows into internal Q/R registers; busy=1 from T0+1.
  - Inputs may change after T0 without affecting the result.
- MAC:
  - Cycles T0+1..T0+64 perform one product per cycle.
  - Loop order: row i (outer), column j, inner index k, with k fastest.
  - Each cycle computes acc += Qreg[i][k]*Rreg[k][j] as a signed ELEM_W x ELEM_W product, sign-extended to ACC_W.
  - On k=0 the accumulator is loaded with the product, not added to it.
  - On k=3 the final sum (acc + current product) is rounded and saturated, then written to element j of output row i in the same cycle.
  - Other output elements hold their previous values while being rebuilt.
- Rounding: add 2^(FRAC-1), then arithmetic shift right by FRAC (round half up).
- Saturation: clamp the result to [-2^(ELEM_W-1), 2^(ELEM_W-1)-1], i.e. 0x8000..0x7FFF at defaults.
- Completion:
  - At edge T0+64: last element written, busy->0, done=1 for exactly one cycle (the T0+65 cycle).
  - FSM returns to IDLE; total latency from start to done is 65 cycles.
- start while busy=1 is ignored (not queued).
- start in the same cycle that done is high is accepted as a new T0.
- A0..A3 keep the last result until reset or until overwritten by the next computation.
- No division and no dependence on R actually being upper-triangular; the full product is computed.

Decomposition:
- Shared package qr_pkg: ELEM_W, FRAC, N=4, ROW_W=N*ELEM_W, ACC_W, the saturation limits, and an element-extract function (row, column -> signed element).
- The same package is reused by the decomposition and inverse blocks.
- One natural sub-module, qr_mac_sat: a combinational signed multiply, add-or-load, round-and-saturate stage. The FSM, index counters and output registers stay in qr_recompose.

Test Plan:
- Identity: Q=I (diagonal 0x0100), R rows diag 0x0200 with R0 element 1 = 0x0080 -> A equals R exactly; done at exactly start+65; busy high 64 cycles.
- Negative / sign: Q=-I (diagonal 0xFF00), R=I -> A diagonal 0xFF00, off-diagonal 0x0000.
- Saturation: Q all elements 0x0100, R all elements 0x4000 -> every A element saturates to 0x7FFF. Flip R to 0xC000 -> every element 0x8000.
- Rounding: Q=0.5*I (0x0080), R0 element 0 = 0x0001, R1 element 1 = 0xFFFF -> A0[col0]=0x0001 (0x80 rounds up); A1[col1]=0x0000 (-0x80+0x80=0).
- Handshake: pulse start again at start+10 with different inputs -> ignored; result matches the first inputs. Then pulse start on the done cycle -> second result, second done at +65.
- Reset mid-op: drive reset low at start+30 for 2 cycles -> A0..A3=0, busy=0 immediately (async); no done pulse. A fresh start then completes normally.
